// File: rtl/wb2core.sv
// wb2core
// Bridges a Wishbone B4 pipelined slave port onto a core-style device port
// (req/gnt/rvalid handshake as used by Ibex/OBI data interfaces).
//
// Requests pass straight through combinationally. Up to MAX_OUTSTANDING
// granted requests may wait for their responses. Responses come back to
// Wishbone one cycle after rvalid. If the initiator drops wb_cyc_i while
// responses are still owed, the bridge drains and discards them. It accepts
// nothing new until the device has answered every outstanding request.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   wb_cyc_i .. wb_sel_i  Wishbone request inputs
//   wb_stall_o            high whenever the current beat is not accepted
//   wb_ack_o, wb_err_o    registered normal / error termination
//   wb_dat_o              registered read data, held between responses
//   dev_req_o .. dev_wdata_o  device request, driven from the Wishbone inputs
//   dev_gnt_i             device accepts the request this cycle
//   dev_rvalid_i, dev_err_i, dev_rdata_i  in-order device response
//   spurious_o            one-cycle pulse when rvalid arrives with nothing owed
module wb2core #(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_OUTSTANDING = 2,
   localparam int SELW           = DW / 8
) (
   input  logic            clk,
   input  logic            rst_n,

   input  logic            wb_cyc_i,
   input  logic            wb_stb_i,
   input  logic            wb_we_i,
   input  logic [AW-1:0]   wb_adr_i,
   input  logic [DW-1:0]   wb_dat_i,
   input  logic [SELW-1:0] wb_sel_i,
   output logic            wb_stall_o,
   output logic            wb_ack_o,
   output logic            wb_err_o,
   output logic [DW-1:0]   wb_dat_o,

   output logic            dev_req_o,
   input  logic            dev_gnt_i,
   output logic            dev_we_o,
   output logic [AW-1:0]   dev_addr_o,
   output logic [SELW-1:0] dev_be_o,
   output logic [DW-1:0]   dev_wdata_o,
   input  logic            dev_rvalid_i,
   input  logic            dev_err_i,
   input  logic [DW-1:0]   dev_rdata_i,

   output logic            spurious_o
);

   localparam int CW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DRAIN
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          full;
   logic          accept;
   logic          resp;

   // Request path: the Wishbone beat is offered to the device unless the
   // outstanding window is full or a drain is still in progress. Stall is
   // the inverse of acceptance, so it is also high when no strobe is present.
   assign full        = (cnt == CW'(MAX_OUTSTANDING));
   assign dev_req_o   = wb_cyc_i & wb_stb_i & ~full & (state != DRAIN);
   assign dev_we_o    = wb_we_i;
   assign dev_addr_o  = wb_adr_i;
   assign dev_be_o    = wb_sel_i;
   assign dev_wdata_o = wb_dat_i;
   assign accept      = dev_req_o & dev_gnt_i;
   assign wb_stall_o  = ~accept;

   // A response only counts when something is owed. An rvalid with a zero
   // count is reported as spurious and otherwise ignored.
   assign resp = dev_rvalid_i & (cnt != '0);

   // The next outstanding count is needed by the FSM to decide when it can
   // return to IDLE in the same edge that retires the last response. An
   // accept and a response in the same cycle cancel out.
   always_comb begin
      cnt_next = cnt;
      if (accept && !resp) begin
         cnt_next = cnt + CW'(1);
      end else if (resp && !accept) begin
         cnt_next = cnt - CW'(1);
      end
   end

   // Single sequential block for the FSM, the outstanding counter and the
   // registered response outputs. While draining, or once the initiator
   // has dropped its cycle, responses still retire the counter. They do not
   // terminate a Wishbone beat. Read data is captured on every counted
   // response and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         wb_ack_o   <= 1'b0;
         wb_err_o   <= 1'b0;
         wb_dat_o   <= '0;
         spurious_o <= 1'b0;
      end else begin
         cnt        <= cnt_next;
         wb_ack_o   <= resp & ~dev_err_i & wb_cyc_i & (state != DRAIN);
         wb_err_o   <= resp & dev_err_i & wb_cyc_i & (state != DRAIN);
         spurious_o <= dev_rvalid_i & (cnt == '0);
         if (resp) begin
            wb_dat_o <= dev_rdata_i;
         end

         unique case (state)
            IDLE: begin
               if (accept) begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt_next == '0) begin
                  state <= IDLE;
               end else if (!wb_cyc_i) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_next == '0) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb2core.sv
// tb_wb2core
// Self-checking bench for wb2core (AW=DW=32, MAX_OUTSTANDING=2).
// A behavioural model keeps a queue of granted-but-unanswered requests and
// an "aborted" flag. On every falling edge it compares all DUT outputs with
// the values the model predicts. It then advances the model by the coming
// rising edge. Directed sequences also pin a few hand-computed literal values.
module tb_wb2core;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MAXO = 2;
   localparam int SELW = DW / 8;

   logic            clk;
   logic            rst_n;
   logic            wb_cyc_i;
   logic            wb_stb_i;
   logic            wb_we_i;
   logic [AW-1:0]   wb_adr_i;
   logic [DW-1:0]   wb_dat_i;
   logic [SELW-1:0] wb_sel_i;
   logic            wb_stall_o;
   logic            wb_ack_o;
   logic            wb_err_o;
   logic [DW-1:0]   wb_dat_o;
   logic            dev_req_o;
   logic            dev_gnt_i;
   logic            dev_we_o;
   logic [AW-1:0]   dev_addr_o;
   logic [SELW-1:0] dev_be_o;
   logic [DW-1:0]   dev_wdata_o;
   logic            dev_rvalid_i;
   logic            dev_err_i;
   logic [DW-1:0]   dev_rdata_i;
   logic            spurious_o;

   int tests    = 0;
   int failures = 0;

   wb2core #(
      .AW(AW),
      .DW(DW),
      .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i),
      .wb_we_i(wb_we_i),
      .wb_adr_i(wb_adr_i),
      .wb_dat_i(wb_dat_i),
      .wb_sel_i(wb_sel_i),
      .wb_stall_o(wb_stall_o),
      .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o),
      .wb_dat_o(wb_dat_o),
      .dev_req_o(dev_req_o),
      .dev_gnt_i(dev_gnt_i),
      .dev_we_o(dev_we_o),
      .dev_addr_o(dev_addr_o),
      .dev_be_o(dev_be_o),
      .dev_wdata_o(dev_wdata_o),
      .dev_rvalid_i(dev_rvalid_i),
      .dev_err_i(dev_err_i),
      .dev_rdata_i(dev_rdata_i),
      .spurious_o(spurious_o)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle's worth of inputs. Write data and byte selects are
   // derived from the address so that the pass-through checks see varied values.
   task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                input logic [31:0] adr, input logic gnt,
                                input logic rvalid, input logic err,
                                input logic [31:0] rdata);
      wb_cyc_i     = cyc;
      wb_stb_i     = stb;
      wb_we_i      = we;
      wb_adr_i     = adr;
      wb_dat_i     = {adr[15:0], ~adr[15:0]};
      wb_sel_i     = adr[5:2] | 4'h1;
      dev_gnt_i    = gnt;
      dev_rvalid_i = rvalid;
      dev_err_i    = err;
      dev_rdata_i  = rdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model state: queue of owed responses, abort flag, and the
   // values the registered outputs must show after the next rising edge.
   logic [31:0] pending[$];
   logic        aborted  = 1'b0;
   logic        exp_ack  = 1'b0;
   logic        exp_err  = 1'b0;
   logic        exp_spur = 1'b0;
   logic [31:0] exp_dat  = '0;

   // Compare and model-advance process. Inputs change just after rising
   // edges, so at the falling edge they are stable for the coming edge.
   always @(negedge clk) begin : model
      int   owed;
      logic exp_req;
      logic acc;
      logic rsp;
      if (!rst_n) begin
         checkOutput("reset_ack", {31'b0, wb_ack_o}, 32'd0);
         checkOutput("reset_err", {31'b0, wb_err_o}, 32'd0);
         checkOutput("reset_spur", {31'b0, spurious_o}, 32'd0);
         checkOutput("reset_dat", wb_dat_o, 32'd0);
         pending.delete();
         aborted  = 1'b0;
         exp_ack  = 1'b0;
         exp_err  = 1'b0;
         exp_spur = 1'b0;
         exp_dat  = '0;
      end else begin
         owed    = pending.size();
         exp_req = wb_cyc_i & wb_stb_i & (owed < MAXO) & ~aborted;
         checkOutput("dev_req", {31'b0, dev_req_o}, {31'b0, exp_req});
         checkOutput("stall", {31'b0, wb_stall_o}, {31'b0, ~(exp_req & dev_gnt_i)});
         checkOutput("ack", {31'b0, wb_ack_o}, {31'b0, exp_ack});
         checkOutput("err", {31'b0, wb_err_o}, {31'b0, exp_err});
         checkOutput("spurious", {31'b0, spurious_o}, {31'b0, exp_spur});
         checkOutput("rdata", wb_dat_o, exp_dat);
         checkOutput("dev_addr", dev_addr_o, wb_adr_i);
         checkOutput("dev_wdata", dev_wdata_o, wb_dat_i);
         checkOutput("dev_be_we", {27'b0, dev_we_o, dev_be_o}, {27'b0, wb_we_i, wb_sel_i});

         acc      = exp_req & dev_gnt_i;
         rsp      = dev_rvalid_i & (owed > 0);
         exp_ack  = rsp & ~dev_err_i & wb_cyc_i & ~aborted;
         exp_err  = rsp & dev_err_i & wb_cyc_i & ~aborted;
         exp_spur = dev_rvalid_i & (owed == 0);
         if (rsp) begin
            void'(pending.pop_front());
            exp_dat = dev_rdata_i;
         end
         if (acc) begin
            pending.push_back(wb_adr_i);
         end
         if (pending.size() == 0) begin
            aborted = 1'b0;
         end else if (!wb_cyc_i) begin
            aborted = 1'b1;
         end
      end
   end

   // Directed sequences with literal expectations at the key points.
   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkOutput("lit_reset_ack", {31'b0, wb_ack_o}, 32'd0);
      checkOutput("lit_reset_stall", {31'b0, wb_stall_o}, 32'd1);

      // Single read to 0x100, response two cycles after the grant.
      applyStimulus(1, 1, 0, 32'h100, 1, 0, 0, 32'h0);
      #1;
      checkOutput("lit_read_stall", {31'b0, wb_stall_o}, 32'd0);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 32'hDEADBEEF);
      tick();
      checkOutput("lit_read_ack", {31'b0, wb_ack_o}, 32'd1);
      checkOutput("lit_read_dat", wb_dat_o, 32'hDEADBEEF);
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();
      checkOutput("lit_read_ack_gone", {31'b0, wb_ack_o}, 32'd0);

      // Pipelined writes: the third beat waits for the first response.
      applyStimulus(1, 1, 1, 32'h0, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 1, 1, 32'h4, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 1, 1, 32'h8, 1, 0, 0, 32'h0);
      #1;
      checkOutput("lit_full_req", {31'b0, dev_req_o}, 32'd0);
      tick();
      applyStimulus(1, 1, 1, 32'h8, 1, 1, 0, 32'h0);
      #1;
      checkOutput("lit_full_rvalid_req", {31'b0, dev_req_o}, 32'd0);
      tick();
      applyStimulus(1, 1, 1, 32'h8, 1, 1, 0, 32'h0);
      #1;
      checkOutput("lit_third_req", {31'b0, dev_req_o}, 32'd1);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
      tick();
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();

      // Full window with a response and a new strobe in the same cycle.
      applyStimulus(1, 1, 0, 32'h200, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 1, 0, 32'h204, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 1, 0, 32'h208, 1, 1, 0, 32'h11111111);
      tick();
      applyStimulus(1, 1, 0, 32'h208, 1, 0, 0, 32'h0);
      #1;
      checkOutput("lit_after_full_req", {31'b0, dev_req_o}, 32'd1);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 32'h22222222);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 32'h33333333);
      tick();
      checkOutput("lit_full_last_dat", wb_dat_o, 32'h33333333);
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();

      // Abort with two reads owed, then a new cycle raised during the drain.
      applyStimulus(1, 1, 0, 32'h300, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 1, 0, 32'h304, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 1, 0, 32'h400, 1, 0, 0, 32'h0);
      #1;
      checkOutput("lit_drain_stall", {31'b0, wb_stall_o}, 32'd1);
      tick();
      applyStimulus(1, 1, 0, 32'h400, 1, 1, 0, 32'hAAAA0001);
      tick();
      checkOutput("lit_drain_ack1", {31'b0, wb_ack_o}, 32'd0);
      applyStimulus(1, 1, 0, 32'h400, 1, 1, 0, 32'hAAAA0002);
      #1;
      checkOutput("lit_drain_last_req", {31'b0, dev_req_o}, 32'd0);
      tick();
      checkOutput("lit_drain_ack2", {31'b0, wb_ack_o}, 32'd0);
      applyStimulus(1, 1, 0, 32'h400, 1, 0, 0, 32'h0);
      #1;
      checkOutput("lit_post_drain_stall", {31'b0, wb_stall_o}, 32'd0);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 0, 32'h12345678);
      tick();
      checkOutput("lit_post_drain_ack", {31'b0, wb_ack_o}, 32'd1);
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();

      // Error response.
      applyStimulus(1, 1, 0, 32'h500, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 1, 1, 32'h00000BAD);
      tick();
      checkOutput("lit_err", {30'b0, wb_err_o, wb_ack_o}, 32'd2);
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();
      checkOutput("lit_err_gone", {31'b0, wb_err_o}, 32'd0);

      // Asynchronous reset with one read owed, then a stray response.
      applyStimulus(1, 1, 0, 32'h600, 1, 0, 0, 32'h0);
      tick();
      applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("lit_async_dat", wb_dat_o, 32'd0);
      checkOutput("lit_async_flags", {29'b0, wb_ack_o, wb_err_o, spurious_o}, 32'd0);
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 0, 0, 32'h0, 0, 1, 0, 32'h00000077);
      tick();
      checkOutput("lit_spurious", {30'b0, spurious_o, wb_ack_o}, 32'd2);
      checkOutput("lit_spurious_dat", wb_dat_o, 32'd0);
      applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
      tick();
      checkOutput("lit_spurious_gone", {31'b0, spurious_o}, 32'd0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
